// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple-borrow subtractor, d = a - b - bin, LSB first over WIDTH cycles
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   start, a, b, bin : request and operands, captured when idle
//   busy           : operation in progress
//   done           : one-cycle pulse when d/bout update
//   d, bout        : registered difference and borrow-out, held until next completion
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, r, r_n;
    logic [CW-1:0]    cnt;
    logic             br, di, br_n, last;

    always_comb begin
        di      = sa[0] ^ sb[0] ^ br;
        br_n    = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
        r_n     = {di, r[WIDTH-1:1]};
        last    = cnt == CW'(WIDTH - 1);
        state_n = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    assign busy = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sa  <= a;
                    sb  <= b;
                    br  <= bin;
                    cnt <= '0;
                end
            end else begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_n;
                r   <= r_n;
                cnt <= cnt + 1'b1;
                // final bit goes straight into d so the result lands on the completion edge
                if (last) begin
                    d    <= r_n;
                    bout <= br_n;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 4 and 8
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
    logic [3:0] a4 = '0, b4 = '0, d4;
    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0] a8 = '0, b8 = '0, d8;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of the done cycle
    task automatic op4(input string tag, input logic [3:0] ta, tb, input logic tbin,
                       input logic [3:0] ed, input logic eb, input logic [3:0] pd, input logic pb);
        start4 = 1'b1; a4 = ta; b4 = tb; bin4 = tbin;
        @(negedge clk);
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy"}, busy4, 1);
            chk({tag, " done early"}, done4, 0);
            chk({tag, " d held"}, {bout4, d4}, {pb, pd});
            @(negedge clk);
        end
        chk({tag, " done"}, done4, 1);
        chk({tag, " busy end"}, busy4, 0);
        chk({tag, " d"}, d4, ed);
        chk({tag, " bout"}, bout4, eb);
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, tb, input logic tbin,
                       input logic [7:0] ed, input logic eb);
        start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, " busy"}, busy8, 1);
            chk({tag, " done early"}, done8, 0);
            @(negedge clk);
        end
        chk({tag, " done"}, done8, 1);
        chk({tag, " result"}, {bout8, d8}, {eb, ed});
    endtask

    initial begin
        int npulse;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] ex;
        repeat (2) @(negedge clk);
        chk("rst busy4", busy4, 0);
        chk("rst done4", done4, 0);
        chk("rst d4", {bout4, d4}, 0);
        chk("rst busy8", busy8, 0);
        chk("rst d8", {done8, bout8, d8}, 0);
        rst = 1'b0;
        @(negedge clk);

        op4("9-3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("done one cycle", done4, 0);
        op4("3-9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 4'd6, 1'b0);
        @(negedge clk);
        op4("0-0-1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 4'hA, 1'b1);
        @(negedge clk);
        op4("15-15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 4'hF, 1'b1);
        @(negedge clk);

        // start held through RUN with different operands must be ignored
        npulse = 0;
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1;
        for (int i = 0; i < 4; i++) begin
            chk("held busy", busy4, 1);
            @(negedge clk);
        end
        start4 = 1'b0;
        chk("held done", done4, 1);
        chk("held d", {bout4, d4}, 5'd6);
        for (int i = 0; i < 6; i++) begin
            if (done4) npulse++;
            @(negedge clk);
        end
        chk("held pulses", npulse, 1);
        chk("held idle", busy4, 0);

        // back-to-back: start in the done cycle
        op4("b2b first", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 4'd6, 1'b0);
        op4("b2b second", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 4'd6, 1'b0);
        @(negedge clk);

        // reset two cycles into RUN aborts with no done
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy4, 0);
        chk("abort done", done4, 0);
        chk("abort d", {bout4, d4}, 0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            if (done4) npulse++;
            @(negedge clk);
        end
        chk("abort no done", npulse, 0);
        op4("after abort", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 4'd0, 1'b0);
        @(negedge clk);

        op8("200-55", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);
        @(negedge clk);
        op8("55-200-1", 8'd55, 8'd200, 1'b1, 8'd110, 1'b1);
        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbin = 1'($urandom);
            ex = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            op8("rand", ra, rb, rbin, ex[7:0], ex[8]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial ripple-borrow subtractor that computes d = a − b − bin one bit per clock, LSB first. It reuses a single full-subtractor cell over WIDTH cycles and exchanges a small area for a WIDTH-cycle latency. It is the subtract-direction companion to the team's ripple-carry adders and sits in datapaths that can tolerate multi-cycle arithmetic. A start/busy/done handshake sequences operations, and the result is held stable until the next completion.

## Interface
Parameters:
- WIDTH, default 4: operand and result width in bits; must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a subtraction; sampled only when not busy.
- a  in  WIDTH  minuend; captured on an accepted start.
- b  in  WIDTH  subtrahend; captured on an accepted start.
- bin  in  1  borrow-in; captured on an accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when d and bout have been updated.
- d  out  WIDTH  difference, registered and held.
- bout  out  1  borrow-out, registered and held. High means a < b + bin as unsigned values.

## Operation
- There are two states, IDLE and RUN. busy = (state == RUN).
- Reset loads the following values:
  - state = IDLE
  - busy = 0, done = 0
  - d = 0, bout = 0
  - internal operand/result shift registers, borrow flop and bit counter = 0
- IDLE behaviour:
  - If start = 1, the block latches a into shift register A and b into shift register B.
  - It loads the borrow flop br with bin, clears the counter and enters RUN.
  - If start = 0, the block stays in IDLE.
- RUN behaviour, each cycle:
  - The block operates on bit a0 = A[0], b0 = B[0].
  - Difference bit: di = a0 ^ b0 ^ br.
  - Next borrow: br' = (~a0 & b0) | (~a0 & br) | (b0 & br).
  - A and B shift right by 1. di shifts into the MSB of result register R. The counter increments.
- Completion: on the RUN cycle with counter = WIDTH−1, the block performs these updates together at one edge:
  - d is loaded with the final R value, including the last bit.
  - bout is loaded with the final br'.
  - done is set to 1.
  - state returns to IDLE.
- Outside completion edges, done is 0. d and bout change only at completion edges or on reset.
- A start asserted while busy = 1 is ignored. It is not queued, and operands presented with it are discarded.
- A start asserted in the cycle where done = 1 is accepted, because the state is IDLE. This allows back-to-back operation with no gap.
- Arithmetic is modulo 2^WIDTH. The concatenation {bout, d} equals the WIDTH+1-bit two's-complement result of a − b − bin.
- Reset during RUN aborts the operation with no done pulse. d and bout go to 0.
- Reset has priority over start.

## Timing
- An accepted start at rising edge k produces the following:
  - busy is high in cycles k+1 … k+WIDTH.
  - d, bout and done update at edge k+WIDTH. done is high for exactly the one cycle after that edge, and busy is low in that cycle.
- Latency from start sample to done is WIDTH cycles. Throughput is one result per WIDTH cycles when back-to-back.
- a, b and bin need only be valid in the cycle start is sampled.
- No combinational path exists from any input to any output. All outputs are registered.

## Test plan
- WIDTH=4: a=9, b=3, bin=0, start pulsed → busy high 4 cycles, then done=1 for one cycle with d=6, bout=0.
- WIDTH=4: a=3, b=9, bin=0 → d=4'hA, bout=1. Then a=0, b=0, bin=1 → d=4'hF, bout=1. Then a=15, b=15, bin=0 → d=0, bout=0.
- Start held high during RUN with different operands (a=1, b=1) → ignored. The first result (9−3=6) is unchanged and done pulses exactly once per accepted start.
- Start asserted in the done cycle with a=5, b=2 → a new operation begins with no idle gap. The second done arrives 4 cycles later with d=3. d holds 6 until then.
- rst asserted 2 cycles into RUN → next cycle busy=0, done=0, d=0, bout=0, and no done pulse follows. A subsequent start runs normally.
- WIDTH=8 instance: a=200, b=55, bin=0 → done after 8 cycles, d=145, bout=0. Then a=55, b=200, bin=1 → d=110, bout=1. Also run a random sweep against {bout, d} = a − b − bin.
